// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        StPllRst,
        StWait,
        StStable,
        StRun
    } state_e;

    localparam int unsigned DefRstPulseCyc   = 16;
    localparam int unsigned DefLockStableCyc = 1024;
    localparam int unsigned DefLockTimeoutCyc = 1000000;
    localparam int unsigned DefCntW          = 20;
    localparam int unsigned RetryW           = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, then releases sys_rst.
// Optional lock-timeout retry is compiled in with PLL_RST_CTRL_TIMEOUT_EN.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DefRstPulseCyc,
    parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
    parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
    parameter int unsigned CNT_W            = DefCntW
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic              lock_lost,
    output logic [RetryW-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYC - 1);

    if (RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 || LOCK_TIMEOUT_CYC < 1 ||
        RST_PULSE_CYC >= (64'd1 << CNT_W) || LOCK_STABLE_CYC >= (64'd1 << CNT_W) ||
        LOCK_TIMEOUT_CYC >= (64'd1 << CNT_W)) begin : g_bad_param
        $error("pll_rst_ctrl: cycle parameter out of range for CNT_W");
    end

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lost_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

`ifdef PLL_RST_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ToLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lock_lost;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end
            end
        endcase

`ifdef PLL_RST_CTRL_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        retry_d = retry_q;
        // Held at zero through PLLRST so it starts fresh on entry to WAIT.
        if (state_q == StPllRst) begin
            tcnt_d = '0;
        end else if (state_q == StWait || state_q == StStable) begin
            if (tcnt_q == ToLast) begin
                state_d = StPllRst;
                cnt_d   = '0;
                tcnt_d  = '0;
                if (retry_q != '1) begin
                    retry_d = retry_q + 1'b1;
                end
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst   <= (state_d == StPllRst);
            sys_rst   <= (state_d != StRun);
            ready     <= (state_d == StRun);
            lock_lost <= lost_d;
        end
    end

`ifdef PLL_RST_CTRL_TIMEOUT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            tcnt_q  <= '0;
            retry_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl: directed scenarios plus random lock activity
// compared each cycle against a behavioural model of the sequencing rules.
module tb_pll_rst_ctrl;

    localparam int unsigned RstCyc    = 4;
    localparam int unsigned StableCyc = 8;
    localparam int unsigned ToCyc     = 100;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, lock_lost;
    logic [7:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int pulse_left, streak, wait_age, m_retry;
    bit run, m_lost, m_s1, m_s2;

    pll_rst_ctrl #(
        .RST_PULSE_CYC    (RstCyc),
        .LOCK_STABLE_CYC  (StableCyc),
        .LOCK_TIMEOUT_CYC (ToCyc),
        .CNT_W            (20)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #10 refclk = ~refclk;

    task automatic model_reset();
        pulse_left = RstCyc;
        streak     = 0;
        wait_age   = 0;
        m_retry    = 0;
        run        = 1'b0;
        m_lost     = 1'b0;
        m_s1       = 1'b0;
        m_s2       = 1'b0;
    endtask

    // One rising edge: the FSM sees lock as it was sampled two edges earlier.
    task automatic model_edge(input bit lk);
        bit ls;
        bit timed_out;
        ls        = m_s2;
        m_s2      = m_s1;
        m_s1      = lk;
        timed_out = 1'b0;
        if (pulse_left > 0) begin
            pulse_left--;
            if (pulse_left == 0) begin
                wait_age = 0;
                streak   = 0;
            end
        end else if (run) begin
            if (!ls) begin
                run        = 1'b0;
                pulse_left = RstCyc;
                m_lost     = 1'b1;
            end
        end else begin
`ifdef PLL_RST_CTRL_TIMEOUT_EN
            if (wait_age == ToCyc - 1) begin
                timed_out  = 1'b1;
                pulse_left = RstCyc;
                if (m_retry < 255) m_retry++;
            end
`endif
            if (!timed_out) begin
                wait_age++;
                streak = ls ? streak + 1 : 0;
                if (streak == StableCyc + 1) run = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pll_rst"},   {7'd0, pll_rst},   {7'd0, pulse_left > 0});
        chk({tag, ".sys_rst"},   {7'd0, sys_rst},   {7'd0, !run});
        chk({tag, ".ready"},     {7'd0, ready},     {7'd0, run});
        chk({tag, ".lock_lost"}, {7'd0, lock_lost}, {7'd0, m_lost});
        chk({tag, ".retry_cnt"}, retry_cnt,         8'(m_retry));
    endtask

    task automatic step(input string tag);
        @(posedge refclk);
        if (!rst) model_edge(locked);
        #1;
        check_all(tag);
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Power-up: lock arrives 10 cycles after reset release
        locked = 1'b0;
        do_reset();
        run_cycles(10, "powerup_wait");
        locked = 1'b1;
        run_cycles(14, "powerup_lock");
        chk("powerup_ready", {7'd0, ready}, 8'd1);

        // Glitch mid stable count restarts the count
        locked = 1'b0;
        do_reset();
        run_cycles(6, "glitch_pre");
        locked = 1'b1;
        run_cycles(6, "glitch_stable");
        locked = 1'b0;
        step("glitch_drop");
        locked = 1'b1;
        run_cycles(14, "glitch_relock");
        chk("glitch_ready", {7'd0, ready}, 8'd1);

        // Loss of lock in RUN; lock_lost remains after relock
        locked = 1'b0;
        run_cycles(3, "loss_drop");
        chk("loss_flag", {7'd0, lock_lost}, 8'd1);
        run_cycles(5, "loss_pulse");
        locked = 1'b1;
        run_cycles(20, "loss_relock");
        chk("loss_sticky", {7'd0, lock_lost}, 8'd1);

        // Async reset between edges while in RUN
        @(posedge refclk);
        model_edge(locked);
        #5;
        rst = 1'b1;
        #1;
        chk("arst.pll_rst",   {7'd0, pll_rst},   8'd1);
        chk("arst.sys_rst",   {7'd0, sys_rst},   8'd1);
        chk("arst.ready",     {7'd0, ready},     8'd0);
        chk("arst.lock_lost", {7'd0, lock_lost}, 8'd0);
        chk("arst.retry_cnt", retry_cnt,         8'd0);
        model_reset();
        @(negedge refclk);
        rst = 1'b0;

        // Randomized lock activity, biased toward long high runs
        for (int blk = 0; blk < 250; blk++) begin
            locked = ($urandom_range(0, 3) != 0);
            run_cycles(locked ? $urandom_range(1, 30) : $urandom_range(1, 6), "random");
        end

        // Lock held low for a long time
        locked = 1'b0;
        do_reset();
`ifdef PLL_RST_CTRL_TIMEOUT_EN
        run_cycles(104 * 258, "timeout");
        chk("timeout_sat", retry_cnt, 8'd255);
`else
        run_cycles(10000, "no_timeout");
        chk("no_timeout_retry", retry_cnt, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

Reset sequencer for the display clock PLL. It runs on the free-running 50 MHz board clock. It drives the PLL's reset input, watches the PLL's `locked` output, and releases a system reset to the Game-of-Life display logic only once lock has been stable for a programmed time. On loss of lock it re-asserts the system reset and re-runs the PLL reset sequence. An optional lock-timeout retry mechanism can be compiled in.

## Interface
Parameters:
- `RST_PULSE_CYC`, 16: refclk cycles that `pll_rst` is held high per PLL reset pulse.
- `LOCK_STABLE_CYC`, 1024: consecutive cycles of synchronized lock required before `sys_rst` is released.
- `LOCK_TIMEOUT_CYC`, 1000000: cycles (20 ms) allowed from end of PLL reset to lock release. Used only with the timeout feature.
- `CNT_W`, 20: shared counter width. Every cycle parameter must be ≥1 and <2^CNT_W.

Ports:
- `refclk` in 1: 50 MHz free-running clock. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock status, asynchronous to refclk.
- `pll_rst` out 1: reset to the PLL. Reset value 1.
- `sys_rst` out 1: registered reset to downstream logic. Reset value 1.
- `ready` out 1: high in RUN only. Reset value 0.
- `lock_lost` out 1: sticky flag, set on any loss of lock in RUN. Cleared only by `rst`. Reset value 0.
- `retry_cnt` out 8: number of lock timeouts, saturating at 255. Reset value 0.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. The synchronizer flops reset to 0.
- FSM states:
  - PLLRST: `pll_rst`=1 and `sys_rst`=1. The counter runs 0..`RST_PULSE_CYC`-1, then the FSM goes to WAIT with the counter cleared.
  - WAIT: `pll_rst`=0. When `locked_s`=1, go to STABLE with the counter cleared.
  - STABLE: `locked_s`=0 returns to WAIT with the counter cleared; this is a glitch restart. `locked_s`=1 with counter==`LOCK_STABLE_CYC`-1 goes to RUN. Otherwise the counter increments.
  - RUN: `sys_rst`=0 and `ready`=1. `locked_s`=0 goes to PLLRST with the counter cleared and sets `lock_lost`.
- `pll_rst`, `sys_rst` and `ready` are registered from next-state. They are never decoded combinationally.
- Entry into RUN is the only way to deassert `sys_rst`. `sys_rst` is 1 in every other state.
- Reset mid-operation: all flops take their reset values immediately (asynchronously). The sequence restarts in PLLRST on the first edge after `rst` falls.

## Timing
- After `rst` falls, `pll_rst` stays high for exactly `RST_PULSE_CYC` rising edges, then falls.
- Edge E is the first edge that samples `locked`=1 into sync flop 1. `sys_rst` falls and `ready` rises at edge E+`LOCK_STABLE_CYC`+2, provided `locked` stays high throughout.
- Loss of lock: `locked` is sampled low at edge L. `sys_rst`=1, `pll_rst`=1 and `lock_lost`=1 all take effect at edge L+2.
- A lock glitch of one or more cycles during STABLE restarts the full `LOCK_STABLE_CYC` count.
- Counter arithmetic is unsigned, `CNT_W` bits. Comparisons are equality against parameter minus 1, so the counter never wraps.

## Configuration
- Macro: `PLL_RST_CTRL_TIMEOUT_EN`.
- Defined:
  - A timeout counter clears on entry to WAIT from PLLRST and counts in both WAIT and STABLE.
  - When it reaches `LOCK_TIMEOUT_CYC`-1 without reaching RUN, the FSM goes to PLLRST on the next edge and `retry_cnt` increments, saturating at 255.
  - Timeout takes priority over a simultaneous STABLE→RUN transition.
- Undefined:
  - There is no timeout counter logic. WAIT and STABLE wait indefinitely.
  - `retry_cnt` is tied to 0.

## Structure
- Package `pll_rst_ctrl_pkg` holds:
  - the state enum: PLLRST, WAIT, STABLE, RUN;
  - default cycle constants;
  - the `retry_cnt` width constant of 8.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-high reset and reset value 0. It is used for `locked`.

## Test plan
Parameters for all scenarios: `RST_PULSE_CYC`=4, `LOCK_STABLE_CYC`=8, `LOCK_TIMEOUT_CYC`=100.
- **Power-up:** release `rst`, then raise `locked` 10 cycles later → `pll_rst` high for 4 edges; `sys_rst` falls 10 edges after `locked` is first sampled high; `ready`=1.
- **Lock glitch:** drop `locked` for 1 cycle midway through the 8-cycle stable count → `sys_rst` stays 1; release occurs 10 edges after `locked` is re-sampled high.
- **Loss of lock:** drop `locked` in RUN → `sys_rst`=1, `pll_rst`=1 and `lock_lost`=1 two edges later. `pll_rst` pulses for 4 cycles. `lock_lost` stays 1 after relock.
- **Timeout (macro on):** hold `locked`=0 → PLLRST re-entered every 104 cycles; `retry_cnt` reads 1, 2, 3…, saturating at 255.
- **No timeout (macro off):** hold `locked`=0 for 10000 cycles → `pll_rst`=0, `sys_rst`=1, `retry_cnt`=0 throughout.
- **Async reset:** assert `rst` in RUN between clock edges → all outputs go to reset values before the next edge.
